// File: rtl/level_progress_if.sv
// level_progress_if: round-event inputs and progress/status outputs of the level tracker
interface level_progress_if;
  logic start;
  logic level_pass;
  logic level_fail;
  logic light1;
  logic light2;
  logic light3;
  logic game_win;
  logic game_over;
  logic playing;
  logic [1:0] cur_level;
  modport master (
    output start, level_pass, level_fail,
    input light1, light2, light3, game_win, game_over, playing, cur_level
  );
  modport slave (
    input start, level_pass, level_fail,
    output light1, light2, light3, game_win, game_over, playing, cur_level
  );
endinterface

// File: rtl/level_progress_ctrl.sv
// level_progress_ctrl: three-level game tracker with thermometer lights and timed win/lose hold
module level_progress_ctrl #(
  parameter int HOLD_CYCLES = 50000000,
  parameter int CNT_W = 26
) (
  input logic clk,
  input logic rst,
  level_progress_if.slave bus
);
  typedef enum logic [2:0] {IDLE, L1, L2, L3, WIN, LOSE} state_t;
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic start_h, pass_h, fail_h;
  logic start_ev, pass_ev, fail_ev;
  assign start_ev = bus.start & ~start_h;
  assign pass_ev = bus.level_pass & ~pass_h;
  assign fail_ev = bus.level_fail & ~fail_h;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      {start_h, pass_h, fail_h} <= '0;
      {bus.light1, bus.light2, bus.light3} <= '0;
      {bus.game_win, bus.game_over, bus.playing} <= '0;
      bus.cur_level <= '0;
    end else begin
      start_h <= bus.start;
      pass_h <= bus.level_pass;
      fail_h <= bus.level_fail;
      if (start_ev) begin
        state <= L1;
        cnt <= '0;
        {bus.light1, bus.light2, bus.light3} <= '0;
        {bus.game_win, bus.game_over, bus.playing} <= 3'b001;
        bus.cur_level <= 2'd1;
      end else begin
        case (state)
          L1, L2, L3: begin
            if (fail_ev) begin
              state <= LOSE;
              bus.game_over <= 1'b1;
              bus.playing <= 1'b0;
              bus.cur_level <= 2'd0;
            end else if (pass_ev) begin
              case (state)
                L1: begin
                  state <= L2;
                  bus.light1 <= 1'b1;
                  bus.cur_level <= 2'd2;
                end
                L2: begin
                  state <= L3;
                  bus.light2 <= 1'b1;
                  bus.cur_level <= 2'd3;
                end
                default: begin
                  state <= WIN;
                  bus.light3 <= 1'b1;
                  bus.game_win <= 1'b1;
                  bus.playing <= 1'b0;
                  bus.cur_level <= 2'd0;
                end
              endcase
            end
          end
          WIN, LOSE: begin
            // exit on the last hold cycle so the counter never wraps
            if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
              state <= IDLE;
              cnt <= '0;
              bus.game_win <= 1'b0;
              bus.game_over <= 1'b0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          default: cnt <= '0;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_level_progress_ctrl.sv
// tb_level_progress_ctrl: directed stimulus checked every cycle against a phase/level model
module tb_level_progress_ctrl;
  localparam int HOLD = 4;
  logic clk = 0;
  logic rst = 1;
  int checks = 0;
  int fails = 0;
  bit armed = 0;
  level_progress_if bus ();
  level_progress_ctrl #(.HOLD_CYCLES(HOLD), .CNT_W(3)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  // model: phase 0 idle, 1 playing, 2 won, 3 lost; done = levels completed
  int phase = 0, lvl = 0, done = 0, held = 0;
  bit ps = 0, pp = 0, pf = 0;
  always @(posedge clk) begin
    bit se, pe, fe;
    se = bus.start && !ps;
    pe = bus.level_pass && !pp;
    fe = bus.level_fail && !pf;
    ps = bus.start;
    pp = bus.level_pass;
    pf = bus.level_fail;
    if (rst) begin
      phase = 0; lvl = 0; done = 0; held = 0; ps = 0; pp = 0; pf = 0;
    end else if (se) begin
      phase = 1; lvl = 1; done = 0; held = 0;
    end else if (phase == 1) begin
      if (fe) begin
        phase = 3; held = 0;
      end else if (pe) begin
        done = lvl;
        if (lvl == 3) begin
          phase = 2; held = 0;
        end else lvl++;
      end
    end else if (phase >= 2) begin
      held++;
      if (held == HOLD) phase = 0;
    end
  end

  always @(negedge clk) begin
    logic [7:0] act, exp;
    if (armed) begin
      act = {bus.light1, bus.light2, bus.light3, bus.game_win, bus.game_over, bus.playing, bus.cur_level};
      exp = {done >= 1, done >= 2, done >= 3, phase == 2, phase == 3, phase == 1,
             phase == 1 ? 2'(lvl) : 2'd0};
      checks++;
      if (act !== exp) begin
        fails++;
        $display("FAIL outputs t=%0t actual=%b expected=%b", $time, act, exp);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s t=%0t actual=%0d expected=%0d", name, $time, act, exp);
    end
  endtask

  task automatic step(input bit s, input bit p, input bit f, input int n);
    bus.start = s;
    bus.level_pass = p;
    bus.level_fail = f;
    repeat (n) @(negedge clk);
    #2;
  endtask

  function automatic int lights();
    return {bus.light1, bus.light2, bus.light3};
  endfunction

  initial begin
    bus.start = 0; bus.level_pass = 0; bus.level_fail = 0;
    repeat (2) @(negedge clk);
    #2;
    armed = 1;
    chk("reset_lights", lights(), 0);
    chk("reset_playing", bus.playing, 0);
    chk("reset_status", {bus.game_win, bus.game_over}, 0);
    rst = 0;
    step(0, 1, 0, 1); step(0, 0, 0, 1);
    chk("idle_pass_ignored", {bus.playing, bus.cur_level}, 0);
    step(1, 0, 0, 1);
    chk("start_level", bus.cur_level, 1);
    step(0, 0, 0, 2); step(0, 1, 0, 1);
    chk("win_l1_lights", lights(), 3'b100);
    chk("win_l1_level", bus.cur_level, 2);
    step(0, 0, 0, 2); step(0, 1, 0, 1);
    chk("win_l2_lights", lights(), 3'b110);
    step(0, 0, 0, 2); step(0, 1, 0, 1);
    chk("win_entry", {bus.game_win, bus.playing, bus.cur_level}, 4'b1000);
    step(0, 0, 0, 3);
    chk("win_hold_last", bus.game_win, 1);
    step(0, 0, 0, 1);
    chk("win_done", bus.game_win, 0);
    chk("win_lights_kept", lights(), 3'b111);
    step(1, 0, 0, 1);
    chk("restart_clears", lights(), 0);
    step(0, 0, 0, 1); step(0, 1, 0, 1); step(0, 0, 0, 1); step(0, 0, 1, 1);
    chk("lose_entry", {bus.game_over, bus.light1, bus.light2}, 3'b110);
    step(0, 0, 0, 3);
    chk("lose_hold_last", bus.game_over, 1);
    step(0, 0, 0, 1);
    chk("lose_done", bus.game_over, 0);
    step(0, 1, 0, 1); step(0, 0, 0, 1);
    chk("lose_lights_kept", lights(), 3'b100);
    step(1, 0, 0, 1); step(0, 0, 0, 1); step(0, 1, 0, 1); step(0, 0, 0, 1);
    step(0, 1, 1, 1);
    chk("pass_fail_same", {bus.game_over, bus.light2}, 2'b10);
    step(0, 0, 0, 4); step(1, 0, 0, 1); step(0, 0, 0, 1);
    step(1, 0, 1, 1);
    chk("start_over_fail", {bus.game_over, bus.cur_level}, 3'b001);
    step(0, 0, 0, 1);
    step(0, 1, 0, 10);
    chk("held_pass", {bus.cur_level, bus.light1, bus.light2}, 4'b1010);
    step(0, 0, 0, 1); step(0, 1, 0, 1); step(0, 0, 0, 1); step(0, 1, 0, 1);
    step(0, 0, 0, 1);
    chk("abort_before", bus.game_win, 1);
    step(1, 0, 0, 1);
    chk("abort_win", {bus.game_win, bus.cur_level}, 3'b001);
    chk("abort_lights", lights(), 0);
    step(0, 0, 0, 1); step(0, 1, 0, 1); step(0, 0, 0, 1); step(0, 1, 0, 1);
    chk("pre_rst_level", bus.cur_level, 3);
    rst = 1;
    step(0, 0, 0, 1);
    chk("rst_mid_game", {lights(), bus.game_win, bus.game_over, bus.playing, bus.cur_level}, 0);
    rst = 0;
    step(0, 0, 0, 2);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/level_progress_ctrl.md
Name: level_progress_ctrl

Overview:
- Sequential game-progress tracker for the reflex game.
- Consumes per-level pass/fail events from the round logic and produces the level-completion flags light1/light2/light3, which drive the win-LED display stage.
- Also produces win and game-over status pulses with a timed hold.
- Sits between the round/timing logic and the LED display block.

Parameters:
- HOLD_CYCLES, 50000000: cycles game_win / game_over stay asserted before returning to IDLE (1 s at 50 MHz); legal range 1..2^26-1.
- CNT_W, 26: width of the hold counter; must satisfy 2^CNT_W > HOLD_CYCLES.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  level-sensitive request to begin a new game; rising edge detected internally.
- level_pass  input  1  current level passed; rising edge detected internally.
- level_fail  input  1  current level failed; rising edge detected internally.
- light1  output  1  registered; level 1 completed.
- light2  output  1  registered; level 2 completed.
- light3  output  1  registered; level 3 completed.
- game_win  output  1  registered; high during the WIN hold.
- game_over  output  1  registered; high during the LOSE hold.
- playing  output  1  registered; high in L1, L2 or L3.
- cur_level  output  2  registered; 0 = idle/ended, 1..3 = level being played.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE, hold counter=0, all edge-detect history registers=0.
  - All outputs 0.
  - Reset overrides every other input, including mid-game and mid-hold.
- Edge detection:
  - Each of start, level_pass and level_fail has a 1-bit history register.
  - Event = input & ~history.
  - A held-high input generates exactly one event.
- Latency: state and outputs update on the same clock edge at which the event is sampled, i.e. visible one cycle after the input rises.
- States and transitions:
  - IDLE:
    - start event -> L1; lights cleared to 000; playing=1; cur_level=1.
    - pass/fail events are ignored.
    - Lights hold their last values (the display keeps the final result).
  - L1:
    - pass -> L2, light1=1.
    - fail -> LOSE.
  - L2:
    - pass -> L3, light2=1.
    - fail -> LOSE.
  - L3:
    - pass -> WIN, light3=1.
    - fail -> LOSE.
  - WIN:
    - game_win=1, playing=0, cur_level=0, counter counts up from 0.
    - When counter == HOLD_CYCLES-1 -> IDLE, game_win=0, counter=0.
  - LOSE:
    - game_over=1, playing=0, cur_level=0, lights frozen at the levels achieved.
    - Exits to IDLE under the same counter rule as WIN.
- Invariant: lights always form a thermometer code. light3 implies light2; light2 implies light1. Encodings 000, 001, 011, 111 only.
- Priority within L1..L3 on the same edge: start > fail > pass.
  - start event in L1..L3 restarts: -> L1, lights 000.
  - Simultaneous fail and pass events: fail wins -> LOSE.
- start in WIN/LOSE:
  - Aborts the hold immediately -> L1, lights 000, counter=0.
  - game_win/game_over drop on that edge.
- Counter:
  - Counts only in WIN/LOSE; held at 0 in all other states.
  - Never wraps, because exit occurs at HOLD_CYCLES-1.
  - HOLD_CYCLES=1 gives a single-cycle pulse.
- Edge history registers update every cycle in every state. An input that rises while ignored does not re-fire later.

Test Plan:
- Reset then idle: rst high 2 cycles, then toggle level_pass -> lights 000, playing 0, cur_level 0, no state change.
- Full win (HOLD_CYCLES=4): start pulse, then three 1-cycle level_pass pulses spaced 3 cycles apart.
  - Lights step 000→001→011→111, each one cycle after its pulse.
  - cur_level 1→2→3→0.
  - game_win high exactly 4 cycles, then IDLE with lights 111 retained.
- Lose at level 2: start, pass, then fail.
  - Lights stay 001.
  - game_over high 4 cycles, then IDLE with lights 001.
  - Subsequent pass is ignored.
- Simultaneous events: in L2 raise level_pass and level_fail on the same cycle -> LOSE, lights 001.
  - Raise start+fail together in L1 -> L1, lights 000, game_over stays 0.
- Held input: keep level_pass high for 10 cycles in L1 -> only L2, light1=1; light2 stays 0.
- Abort and reset mid-operation:
  - start during the 2nd cycle of the WIN hold -> L1, lights 000, game_win 0 next cycle.
  - rst asserted in L3 -> all outputs 0 on that edge.
